// File: rtl/bexkat2_prefetch.sv
// Instruction prefetch for the bexkat2 control unit: single-outstanding bus fetcher
// feeding a small FIFO, with PC-load flush/redirect.
module bexkat2_prefetch #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          pc_load_i,
  input  logic [AW-1:0] pc_new_i,
  output logic          ir_valid_o,
  input  logic          ir_ready_i,
  output logic [31:0]   ir_o,
  output logic [AW-1:0] ir_pc_o,
  output logic          ir_fault_o,
  output logic          bus_cyc_o,
  output logic          bus_stb_o,
  output logic [AW-3:0] bus_adr_o,
  input  logic [31:0]   bus_dat_i,
  input  logic          bus_ack_i,
  input  logic          bus_err_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]    state, state_nx;
  logic          started;
  logic [AW-1:0] fetch_pc;
  logic [AW-3:0] drain_adr;

  logic [31:0]    dat_mem [DEPTH];
  logic [AW-1:0]  pc_mem  [DEPTH];
  logic [DEPTH-1:0] flt_mem;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count, count_nx;

  logic term, push, pop;

  assign term = bus_ack_i | bus_err_i;
  assign push = (state == S_REQ) & term & ~pc_load_i;
  assign pop  = (count != '0) & ir_ready_i & ~pc_load_i;

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + CW'(1);
    else if (pop && !push)
      count_nx = count - CW'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (!pc_load_i && started && (count < CW'(DEPTH)))
          state_nx = S_REQ;
      end
      S_REQ: begin
        if (pc_load_i)
          state_nx = term ? S_IDLE : S_DRAIN;
        else if (bus_err_i)
          state_nx = S_HALT;
        else if (bus_ack_i)
          state_nx = (count_nx < CW'(DEPTH)) ? S_REQ : S_IDLE;
      end
      // Returning through IDLE gives the one-cycle cyc gap before the redirected request.
      S_DRAIN: begin
        if (term)
          state_nx = S_IDLE;
      end
      S_HALT: begin
        if (pc_load_i)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      started   <= 1'b0;
      fetch_pc  <= '0;
      drain_adr <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state <= state_nx;
      if (pc_load_i) begin
        started  <= 1'b1;
        fetch_pc <= pc_new_i & ~AW'(3);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        if (state == S_REQ)
          drain_adr <= fetch_pc[AW-1:2];
      end else begin
        if (push && !bus_err_i)
          fetch_pc <= fetch_pc + AW'(4);
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count_nx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      dat_mem[wr_ptr] <= bus_err_i ? '0 : bus_dat_i;
      pc_mem[wr_ptr]  <= fetch_pc;
      flt_mem[wr_ptr] <= bus_err_i;
    end
  end

  // Head fields are forced to zero when empty so reset and post-flush values are defined.
  assign ir_valid_o = (count != '0);
  assign ir_o       = ir_valid_o ? dat_mem[rd_ptr] : '0;
  assign ir_pc_o    = ir_valid_o ? pc_mem[rd_ptr]  : '0;
  assign ir_fault_o = ir_valid_o & flt_mem[rd_ptr];

  assign bus_cyc_o = (state == S_REQ) | (state == S_DRAIN);
  assign bus_stb_o = bus_cyc_o;
  assign bus_adr_o = (state == S_DRAIN) ? drain_adr : fetch_pc[AW-1:2];

endmodule
